// File: rtl/fetch_seq_pkg.sv
// fetch_pkg: shared state and branch-condition encodings for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_PAR    = 2'b11;
  function automatic logic cond_true(input logic [1:0] c, input logic z, input logic p);
    return c == COND_ALWAYS ? 1'b1 : c == COND_Z ? z : c == COND_NZ ? !z : p;
  endfunction
endpackage

// File: rtl/fetch_seq_if.sv
// fetch_seq_if: host handshake, decoded control and fetch outputs of the sequencer
interface fetch_seq_if #(parameter int D = 10, parameter int C = 16) ();
  logic         req;
  logic [D-1:0] start_addr;
  logic         stall;
  logic         halt;
  logic         jump_en;
  logic         jump_rel;
  logic [1:0]   cond;
  logic         zero_f;
  logic         pari_f;
  logic         call;
  logic         ret;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic         fetch_valid;
  logic         done;
  logic         err;
  logic [C-1:0] instr_cnt;
  modport slave (
    input  req, start_addr, stall, halt, jump_en, jump_rel, cond, zero_f, pari_f, call, ret, target,
    output prog_ctr, fetch_valid, done, err, instr_cnt
  );
  modport master (
    output req, start_addr, stall, halt, jump_en, jump_rel, cond, zero_f, pari_f, call, ret, target,
    input  prog_ctr, fetch_valid, done, err, instr_cnt
  );
endinterface

// File: rtl/fetch_seq_ret_stack.sv
// ret_stack: LIFO of return addresses; top entry is always visible on dout
module ret_stack #(
  parameter int D  = 10,
  parameter int SD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [D-1:0] din,
  output logic [D-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(SD + 1);
  localparam int AW = SD > 1 ? $clog2(SD) : 1;
  logic [PW-1:0] r_sp;
  logic [PW-1:0] w_sp_dec;
  logic [D-1:0]  r_mem [2**AW];
  logic [AW-1:0] w_wa;
  logic [AW-1:0] w_ra;
  assign w_sp_dec = r_sp - PW'(1);
  assign w_wa     = r_sp[AW-1:0];
  assign w_ra     = w_sp_dec[AW-1:0];
  assign full     = r_sp == PW'(SD);
  assign empty    = r_sp == '0;
  assign dout     = r_mem[w_ra];
  // stack pointer: clear wins, pop wins over push, guarded against over/underflow
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sp <= '0;
    else if (clr) r_sp <= '0;
    else if (pop && !empty) r_sp <= w_sp_dec;
    else if (push && !full) r_sp <= r_sp + PW'(1);
  // storage: entries above the pointer are don't-care, so no reset needed
  always_ff @(posedge clk)
    if (push && !full && !pop && !clr) r_mem[w_wa] <= din;
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: program counter, start/finish handshake, jumps and call/return stack
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int D  = 10,
  parameter int SD = 4,
  parameter int C  = 16
) (
  input logic       clk,
  input logic       reset,
  fetch_seq_if.slave bus
);
  state_t       r_state, w_state_nxt;
  logic [D-1:0] r_pc, w_pc_nxt, w_pc_inc, w_top;
  logic [C-1:0] r_cnt;
  logic         r_err, w_err_set;
  logic         w_push, w_pop, w_clr, w_full, w_empty;
  logic         w_go, w_accept;
  assign w_pc_inc        = r_pc + D'(1);
  assign w_go            = r_state == RUN && !bus.stall;
  assign w_accept        = r_state == IDLE && bus.req;
  assign bus.prog_ctr    = r_pc;
  assign bus.fetch_valid = r_state == RUN;
  assign bus.done        = r_state == DONE;
  assign bus.err         = r_err;
  assign bus.instr_cnt   = r_cnt;
  ret_stack #(.D(D), .SD(SD)) u_stack (
    .clk  (clk),
    .reset(reset),
    .push (w_push),
    .pop  (w_pop),
    .clr  (w_clr),
    .din  (w_pc_inc),
    .dout (w_top),
    .full (w_full),
    .empty(w_empty)
  );
  // next state, next PC and stack commands; one action per non-stalled RUN cycle
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: if (bus.req) begin
        w_state_nxt = RUN;
        w_pc_nxt    = bus.start_addr;
        w_clr       = 1'b1;
      end
      RUN: if (!bus.stall) begin
        if (bus.halt) w_state_nxt = DONE;
        else if (bus.ret) begin
          if (w_empty) begin
            w_err_set   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_pc_nxt = w_top;
            w_pop    = 1'b1;
          end
        end else if (bus.call) begin
          if (w_full) begin
            w_err_set   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_pc_nxt = bus.target;
            w_push   = 1'b1;
          end
        end else if (bus.jump_en && cond_true(bus.cond, bus.zero_f, bus.pari_f))
          w_pc_nxt = bus.jump_rel ? r_pc + bus.target : bus.target;
        else w_pc_nxt = w_pc_inc;
      end
      DONE: if (!bus.req) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // state and program counter registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  // sticky fault flag and saturating retire counter, both cleared on an accepted request
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_err_set) r_err <= 1'b1;
      if (w_go && r_cnt != '1) r_cnt <= r_cnt + C'(1);
    end
endmodule

// File: doc/fetch_seq.md
# fetch_seq

Parametrised fetch sequencer replacing the fixed-width PC and the `req`/`done` glue in the processor top level. It holds the program counter and runs a start/finish handshake with the testbench or host. It resolves absolute, relative and flag-conditional jumps, and adds a hardware call/return stack of configurable depth. It drives `prog_ctr` to the instruction ROM and consumes decoded control from the decoder and registered flags from the datapath.

## Interface
- `D`, 10, program counter width
- `SD`, 4, return-stack depth (entries, ≥1)
- `C`, 16, retired-instruction counter width
---
- `clk` in 1: clock, rising-edge
- `reset` in 1: asynchronous, active-low
- `req` in 1: start request, level, sampled in IDLE
- `start_addr` in D: PC loaded when a request is accepted
- `stall` in 1: hold PC this cycle; no retire
- `halt` in 1: current instruction is the program's last
- `jump_en` in 1: current instruction is a jump or branch
- `jump_rel` in 1: 1 = `target` is a signed offset; 0 = absolute
- `cond` in 2: 00 always, 01 zero, 10 not-zero, 11 parity
- `zero_f`, `pari_f` in 1: registered ALU flags
- `call` in 1: push return address, then absolute jump to `target`
- `ret` in 1: pop return address into PC
- `target` in D: jump address or offset
- `prog_ctr` out D: current fetch address
- `fetch_valid` out 1: high in RUN only
- `done` out 1: program finished (normal or fault)
- `err` out 1: stack overflow or underflow occurred; sticky until next accepted `req`
- `instr_cnt` out C: instructions retired in the current run

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with `req`=1: go to RUN. Load `prog_ctr`←`start_addr`, clear `instr_cnt`, `err` and the stack.
- RUN, per non-stalled cycle, applies exactly one action in this priority order:
  1. `halt`: go to DONE, PC holds.
  2. `ret`: PC←top of stack, pop. If the stack is empty: set `err`, go to DONE.
  3. `call`: push `prog_ctr+1`, PC←`target`. If the stack is full: set `err`, go to DONE, no push.
  4. `jump_en` with condition true: PC←`target` (absolute) or `prog_ctr+sext(target)` (relative).
  5. Otherwise: PC←`prog_ctr+1`.
- Condition true: `cond`=00 always; 01 `zero_f`; 10 `!zero_f`; 11 `pari_f`.
- All PC arithmetic is mod 2^D. Increment wraps from 2^D−1 to 0. A relative offset is the D-bit two's-complement value of `target`.
- `instr_cnt` increments on every non-stalled RUN cycle, including the halt, ret, call and fault cycles. It saturates at 2^C−1.
- `stall`=1 in RUN: PC, stack, counter and state all hold. `stall` takes priority over `halt`.
- DONE: `done`=1. Stay in DONE while `req`=1; go to IDLE when `req`=0. A held `req` never restarts a run.
- Simultaneous `call` and `ret` is a decoder error: `ret` wins.
- Control inputs other than `req`/`start_addr` are ignored outside RUN.

## Timing
- Reset values: state IDLE, `prog_ctr`=0, `fetch_valid`=0, `done`=0, `err`=0, `instr_cnt`=0, stack pointer=0.
- `reset` low at any time clears all state immediately, independent of `clk`. This includes mid-run and in DONE.
- All outputs are registered or decoded from the state register only. No combinational path from inputs to outputs.
- Control inputs describe the instruction at the current `prog_ctr`. The next `prog_ctr` is valid after the next rising edge.
- Latency from `req` to the first fetch is 1 edge: `fetch_valid`=1 and `prog_ctr`=`start_addr` after it.
- Latency from `halt` to `done` is 1 edge. `prog_ctr` keeps the halt address in DONE.
- A push or pop takes effect at the same edge as the PC update. Return-to-return sequences need no bubbles.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DONE`);
  - the `cond` encodings `COND_ALWAYS`, `COND_Z`, `COND_NZ`, `COND_PAR`.
- Sub-module `ret_stack` is a LIFO with parameters `D`, `SD`.
  - Inputs: `push`, `pop`, `clr`, `din`.
  - Outputs: `dout` (top), `full`, `empty`.
  - Async active-low reset on the same `reset`.
- PC next-state logic and the FSM live in `fetch_seq`.

## Test plan
- Reset release, `req`=1, `start_addr`=5, no control: after 1 edge `prog_ctr`=5 and `fetch_valid`=1; then 6, 7, … each cycle.
- `halt` at PC 9 after 4 retired: `done`=1 next edge, `prog_ctr`=9, `instr_cnt`=5. Holding `req`=1 keeps DONE; `req`=0 returns to IDLE.
- Relative jump `target`=0x3FE (−2) at PC 20 gives PC 18. `cond`=01 with `zero_f`=0 at PC 18 gives PC 19. `D`=10 with PC 1023 and no jump wraps to 0.
- `call` at PC 3 to `target` 40, then `ret` at PC 41: PC goes 40, 41, 4. With `SD`=2, three nested calls set `err` and `done` on the third.
- `ret` with an empty stack: `err`=1, `done`=1 next edge. `stall`=1 for 3 cycles during `halt`: PC and `instr_cnt` hold until `stall` drops.
- `reset` pulled low mid-run between edges: all outputs read zero before the next edge, state is IDLE.
